demux_scatter: RTL and testbench



---
 rtl/demux_scatter_if.sv | 28 ++
 rtl/demux_scatter.sv | 147 ++++++++++++++
 tb/tb_demux_scatter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/demux_scatter_if.sv
// Handshake/bus bundle for demux_scatter: beat input, frame output and status.
// The slave modport is the scatter block; the master modport is its driver.
interface demux_scatter_if #(
    parameter int LANES = 16,
    parameter int SEL_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel;
    logic             in_bit;
    logic             clear;
    logic [LANES-1:0] q;
    logic [LANES-1:0] written;
    logic             frame_valid;
    logic             frame_ready;
    logic             dup_err;
    logic [3:0]       grp_done;

    modport slave (
        input  in_valid, in_sel, in_bit, clear, frame_ready,
        output in_ready, q, written, frame_valid, dup_err, grp_done
    );

    modport master (
        output in_valid, in_sel, in_bit, clear, frame_ready,
        input  in_ready, q, written, frame_valid, dup_err, grp_done
    );
endinterface

// File: rtl/demux_scatter.sv
// Scatters (select, bit) beats into LANES lanes and hands the full word off as a frame.
// Optional group-complete flags on grp_done are enabled with macro DEMUX_GROUP_DONE_EN.
module demux_scatter #(
    parameter int LANES = 16,
    parameter int SEL_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    demux_scatter_if.slave  bus
);
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    if (LANES < 2 || LANES > 16 || LANES != (1 << SEL_W)) begin : g_bad_cfg
        $error("demux_scatter: LANES must be a power of two in 2..16 equal to 2**SEL_W");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic             r_frame_valid;
    logic             r_dup_err;
    logic [LANES-1:0] r_q;
    logic [LANES-1:0] r_written;
    logic [LANES-1:0] w_lane_we;
    logic [LANES-1:0] w_written_nxt;
    logic             w_accept;
    logic             w_dup;
    logic             w_handoff;
    logic             w_flush;
    logic [3:0]       w_grp;

    // Beat acceptance, lane decode and next-state selection.
    always_comb begin
        w_accept      = bus.in_valid & r_in_ready & ~bus.clear;
        w_lane_we     = {LANES{1'b0}};
        w_dup         = 1'b0;
        w_handoff     = (r_state == ST_HOLD) & r_frame_valid & bus.frame_ready & ~bus.clear;
        w_flush       = bus.clear | w_handoff;
        w_state_nxt   = r_state;
        if (w_accept) begin
            w_lane_we = {{(LANES-1){1'b0}}, 1'b1} << bus.in_sel;
            w_dup     = r_written[bus.in_sel];
        end else begin
            w_lane_we = {LANES{1'b0}};
            w_dup     = 1'b0;
        end
        w_written_nxt = r_written | w_lane_we;
        case (r_state)
            ST_COLLECT: begin
                if (w_accept && (&w_written_nxt)) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (w_handoff) begin
                    w_state_nxt = ST_COLLECT;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_COLLECT;
        endcase
        if (bus.clear) begin
            w_state_nxt = ST_COLLECT;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // State register; in_ready and frame_valid are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_COLLECT;
            r_in_ready    <= 1'b0;
            r_frame_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_in_ready    <= (w_state_nxt == ST_COLLECT);
            r_frame_valid <= (w_state_nxt == ST_HOLD);
        end
    end

    // Sticky duplicate-write flag; only reset or clear removes it, a handoff keeps it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dup_err <= 1'b0;
        end else if (bus.clear) begin
            r_dup_err <= 1'b0;
        end else if (w_dup) begin
            r_dup_err <= 1'b1;
        end else begin
            r_dup_err <= r_dup_err;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Per-lane data bit and written flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q[i]       <= 1'b0;
                r_written[i] <= 1'b0;
            end else if (w_flush) begin
                r_q[i]       <= 1'b0;
                r_written[i] <= 1'b0;
            end else if (w_lane_we[i]) begin
                r_q[i]       <= bus.in_bit;
                r_written[i] <= 1'b1;
            end else begin
                r_q[i]       <= r_q[i];
                r_written[i] <= r_written[i];
            end
        end
    end

`ifdef DEMUX_GROUP_DONE_EN
    // AND of the first n written flags, clipped to the lanes that exist.
    function automatic logic grp_and(input logic [LANES-1:0] w, input int n);
        logic a;
        a = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            if (k < n) begin
                a = a & w[k];
            end else begin
                a = a;
            end
        end
        return a;
    endfunction

    assign w_grp = {grp_and(r_written, LANES), grp_and(r_written, 8),
                    grp_and(r_written, 4), grp_and(r_written, 2)};
`else
    assign w_grp = 4'b0000;
`endif

    assign bus.in_ready    = r_in_ready;
    assign bus.q           = r_q;
    assign bus.written     = r_written;
    assign bus.frame_valid = r_frame_valid;
    assign bus.dup_err     = r_dup_err;
    assign bus.grp_done    = w_grp;
endmodule

// File: tb/tb_demux_scatter.sv
// Table-driven bench for demux_scatter: directed beat vectors with hand-computed results,
// plus a hand-written asynchronous mid-frame reset sequence.
module tb_demux_scatter;
    localparam int LANES = 16;
    localparam int SEL_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_scatter_if #(.LANES(LANES), .SEL_W(SEL_W)) bus ();
    demux_scatter #(.LANES(LANES), .SEL_W(SEL_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        v;
        logic [3:0]  s;
        logic        b;
        logic        c;
        logic        fr;
        logic [15:0] eq;
        logic [15:0] ew;
        logic        efv;
        logic        erdy;
        logic        edup;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [3:0] exp_grp(input logic [15:0] w);
`ifdef DEMUX_GROUP_DONE_EN
        return {&w, &w[7:0], &w[3:0], &w[1:0]};
`else
        return 4'b0000;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic [15:0] eq, input logic [15:0] ew,
                           input logic efv, input logic erdy, input logic edup);
        chk({tag, ".q"},           32'(bus.q),           32'(eq));
        chk({tag, ".written"},     32'(bus.written),     32'(ew));
        chk({tag, ".frame_valid"}, 32'(bus.frame_valid), 32'(efv));
        chk({tag, ".in_ready"},    32'(bus.in_ready),    32'(erdy));
        chk({tag, ".dup_err"},     32'(bus.dup_err),     32'(edup));
        chk({tag, ".grp_done"},    32'(bus.grp_done),    32'(exp_grp(ew)));
    endtask

    task automatic add(input logic v, input int s, input logic b, input logic c, input logic fr,
                       input logic [15:0] eq, input logic [15:0] ew,
                       input logic efv, input logic erdy, input logic edup);
        vec_t t;
        t.v = v; t.s = 4'(s); t.b = b; t.c = c; t.fr = fr;
        t.eq = eq; t.ew = ew; t.efv = efv; t.erdy = erdy; t.edup = edup;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic b,
                         input logic c, input logic fr);
        bus.in_valid    = v;
        bus.in_sel      = s;
        bus.in_bit      = b;
        bus.clear       = c;
        bus.frame_ready = fr;
    endtask

    initial begin
        logic [15:0] q_m;
        logic [15:0] w_m;

        // idle cycle right after reset release
        add(1'b0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        // full frame, sel=0..15, bit=sel[0]
        w_m = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            w_m = w_m | (16'h0001 << i);
            q_m = 16'hAAAA & w_m;
            add(1'b1, i, 1'((i % 2) == 1), 1'b0, 1'b0, q_m, w_m, 1'(i == 15), 1'(i != 15), 1'b0);
        end
        // backpressure: beats offered while holding must be ignored
        for (int i = 0; i < 5; i++)
            add(1'b1, 3, 1'b0, 1'b0, 1'b0, 16'hAAAA, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        // handoff with a beat still presented: beat dropped
        add(1'b1, 3, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        // in_valid=0 ignores sel/bit
        add(1'b0, 7, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        // duplicate write to lane 5
        add(1'b1, 5, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0020, 1'b0, 1'b1, 1'b0);
        add(1'b1, 5, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0020, 1'b0, 1'b1, 1'b1);
        w_m = 16'h0020;
        q_m = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (i != 5) begin
                w_m = w_m | (16'h0001 << i);
                q_m = q_m | (16'h0001 << i);
                add(1'b1, i, 1'b1, 1'b0, 1'b0, q_m, w_m,
                    1'(w_m == 16'hFFFF), 1'(w_m != 16'hFFFF), 1'b1);
            end
        end
        // handoff keeps dup_err, clear drops it
        add(1'b0, 0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        // clear collision after 8 beats
        for (int i = 0; i < 8; i++) begin
            w_m = 16'((32'h1 << (i + 1)) - 1);
            add(1'b1, i, 1'b1, 1'b0, 1'b0, w_m, w_m, 1'b0, 1'b1, 1'b0);
        end
        add(1'b1, 9, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        add(1'b0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset.q",           32'(bus.q),           32'h0);
        chk("reset.written",     32'(bus.written),     32'h0);
        chk("reset.frame_valid", 32'(bus.frame_valid), 32'h0);
        chk("reset.dup_err",     32'(bus.dup_err),     32'h0);
        chk("reset.grp_done",    32'(bus.grp_done),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            if (n != 0) @(negedge clk);
            drive(vecs[n].v, vecs[n].s, vecs[n].b, vecs[n].c, vecs[n].fr);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", n), vecs[n].eq, vecs[n].ew,
                    vecs[n].efv, vecs[n].erdy, vecs[n].edup);
        end

        // asynchronous reset in the middle of a frame
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        chk_all("mid.pre", 16'h0007, 16'h0007, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.rst.q",       32'(bus.q),       32'h0);
        chk("mid.rst.written", 32'(bus.written), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("mid.post", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
